// File: rtl/parity_pkg.sv
// Shared definitions for the odd-parity generator / checker pair:
// receiver FSM states, default widths and the reference parity function.
package parity_pkg;

  localparam int DATA_W_DEF     = 4;
  localparam bit ODD_PARITY_DEF = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Odd convention returns the XNOR of the data bits, so data plus parity always carries an odd number of ones.
  function automatic logic parity_bit(input logic [DATA_W_DEF-1:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/parity_check_rx_if.sv
// Serial-input / parallel-output bundle of the parity checking receiver.
// The master side drives the line and strobes; the slave side is the receiver.
interface parity_check_rx_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);

  logic              bit_en;
  logic              rx_in;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output bit_en, rx_in, clr_err,
    input  data_out, data_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  bit_en, rx_in, clr_err,
    output data_out, data_valid, parity_err, frame_err, busy, err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear on the same edge
// as an increment leaves the count at zero.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/parity_check_rx.sv
// Receiver for start / DATA_W data bits LSB first / parity / stop frames.
// Recovers the word, flags parity and framing errors, and counts bad frames.
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit ODD_PARITY = ODD_PARITY_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  parity_check_rx_if.slave bus
);

  localparam int             BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_W - 1);

  rx_state_t         r_state;
  logic [BW-1:0]     r_bitCnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_ones;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_parErr;
  logic              r_frameErr;

  logic              w_frameDone;
  logic              w_parErrNow;
  logic              w_badFrame;
  logic [CNT_W-1:0]  w_errCount;

  // r_ones already holds data XOR parity by the time STOP is sampled.
  assign w_frameDone = bus.bit_en && (r_state == STOP);
  assign w_parErrNow = ODD_PARITY ? ~r_ones : r_ones;
  assign w_badFrame  = w_frameDone && (w_parErrNow || !bus.rx_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_ones     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.bit_en) begin
        unique case (r_state)
          IDLE: begin
            if (!bus.rx_in) begin
              r_state  <= DATA;
              r_bitCnt <= '0;
              r_ones   <= 1'b0;
            end
          end
          DATA: begin
            r_shift[r_bitCnt] <= bus.rx_in;
            r_ones            <= r_ones ^ bus.rx_in;
            if (r_bitCnt == LAST_BIT) begin
              r_state <= PARITY;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
          PARITY: begin
            r_ones  <= r_ones ^ bus.rx_in;
            r_state <= STOP;
          end
          STOP: begin
            r_state    <= IDLE;
            r_data     <= r_shift;
            r_parErr   <= w_parErrNow;
            r_frameErr <= ~bus.rx_in;
            r_valid    <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_errCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_badFrame),
    .i_clr   (bus.clr_err),
    .o_count (w_errCount)
  );

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_parErr;
  assign bus.frame_err  = r_frameErr;
  assign bus.busy       = (r_state != IDLE);
  assign bus.err_count  = w_errCount;

endmodule

// File: tb/tb_parity_check_rx.sv
// Randomised and directed frames into parity_check_rx; a frame-level model
// predicts each delivered word, its flags, its timing and the error count.
module tb_parity_check_rx;
  import parity_pkg::*;

  typedef struct {
    logic [3:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } expFrame_t;

  logic clk;
  logic rst_n;

  int checks     = 0;
  int failures   = 0;
  int cycleCnt   = 0;
  int validCount = 0;
  int expCount   = 0;
  int qs;
  logic clrSeen   = 1'b0;
  logic prevValid = 1'b0;
  expFrame_t expQ[$];
  expFrame_t monE;

  parity_check_rx_if #(.DATA_W(4), .CNT_W(8)) bus ();

  parity_check_rx #(
    .DATA_W     (4),
    .ODD_PARITY (1'b1),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycleCnt = cycleCnt + 1;
    clrSeen  = bus.clr_err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every delivered word is matched against the oldest outstanding frame; the error count is a plain saturating tally.
  always @(negedge clk) begin
    if (!rst_n) begin
      expCount  = 0;
      prevValid = 1'b0;
    end else begin
      if (bus.data_valid) begin
        validCount++;
        checkOutput("validWidth", prevValid, 1'b0);
        qs = expQ.size();
        checkOutput("expectedFrame", qs != 0, 1'b1);
        if (qs != 0) begin
          monE = expQ.pop_front();
          checkOutput("data", bus.data_out, monE.data);
          checkOutput("parityErr", bus.parity_err, monE.perr);
          checkOutput("frameErr", bus.frame_err, monE.ferr);
          checkOutput("latency", cycleCnt, monE.cyc + 1);
          if (clrSeen) expCount = 0;
          else if (monE.perr || monE.ferr) expCount = (expCount >= 255) ? 255 : expCount + 1;
          checkOutput("errCount", bus.err_count, expCount);
        end
      end else if (clrSeen) begin
        expCount = 0;
        checkOutput("errCountClr", bus.err_count, 0);
      end
      prevValid = bus.data_valid;
    end
  end

  task automatic driveCycle(input logic en, input logic b, input logic clr);
    @(posedge clk);
    #1;
    bus.bit_en  = en;
    bus.rx_in   = b;
    bus.clr_err = clr;
  endtask

  task automatic sendBit(input logic b, input int gap);
    driveCycle(1'b1, b, 1'b0);
    repeat (gap - 1) driveCycle(1'b0, b, 1'b0);
  endtask

  task automatic idleBits(input int n);
    repeat (n) driveCycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic applyStimulus(input logic [3:0] data, input logic par, input logic stop,
                               input int gap, input logic clrAtStop);
    expFrame_t e;
    sendBit(1'b0, gap);
    for (int i = 0; i < 4; i++) begin
      sendBit(data[i], gap);
      if (i == 0) checkOutput("busyInFrame", bus.busy, 1'b1);
    end
    sendBit(par, gap);
    driveCycle(1'b1, stop, clrAtStop);
    e.data = data;
    e.perr = ($countones({data, par}) % 2) == 0;
    e.ferr = ~stop;
    e.cyc  = cycleCnt;
    expQ.push_back(e);
    repeat (gap - 1) driveCycle(1'b0, stop, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vcSnap;
    logic [3:0] d;
    logic p;
    rst_n       = 1'b0;
    bus.bit_en  = 1'b0;
    bus.rx_in   = 1'b1;
    bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstData", bus.data_out, 0);
    checkOutput("rstValid", bus.data_valid, 0);
    checkOutput("rstParErr", bus.parity_err, 0);
    checkOutput("rstFrameErr", bus.frame_err, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstErrCount", bus.err_count, 0);
    rst_n = 1'b1;
    idleBits(2);

    $display("[TB] directed frames");
    applyStimulus(4'hB, 1'b0, 1'b1, 1, 1'b0);
    idleBits(2);
    applyStimulus(4'h0, 1'b1, 1'b1, 1, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1, 1, 1'b0);
    idleBits(2);
    applyStimulus(4'h5, 1'b1, 1'b0, 1, 1'b0);
    idleBits(3);
    checkOutput("idleBusy", bus.busy, 0);
    checkOutput("errAfterDirected", bus.err_count, 2);

    $display("[TB] reset mid-frame");
    vcSnap = validCount;
    sendBit(1'b0, 1);
    sendBit(1'b1, 1);
    sendBit(1'b1, 1);
    @(posedge clk);
    #1;
    bus.bit_en = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstValid", bus.data_valid, 0);
    checkOutput("midRstData", bus.data_out, 0);
    checkOutput("midRstErrCount", bus.err_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleBits(3);
    checkOutput("noValidAfterReset", validCount, vcSnap);
    applyStimulus(4'h3, parity_bit(4'h3, 1'b1), 1'b1, 1, 1'b0);
    idleBits(2);

    $display("[TB] sparse back-to-back");
    vcSnap = validCount;
    applyStimulus(4'hA, parity_bit(4'hA, 1'b1), 1'b1, 5, 1'b0);
    applyStimulus(4'h6, parity_bit(4'h6, 1'b1), 1'b1, 5, 1'b0);
    idleBits(3);
    checkOutput("b2bValids", validCount - vcSnap, 2);

    $display("[TB] counter saturation");
    for (int n = 0; n < 300; n++) begin
      d = 4'($urandom_range(0, 15));
      applyStimulus(d, ~parity_bit(d, 1'b1), 1'b1, 1, 1'b0);
    end
    idleBits(2);
    checkOutput("errSaturated", bus.err_count, 255);
    d = 4'($urandom_range(0, 15));
    applyStimulus(d, ~parity_bit(d, 1'b1), 1'b1, 1, 1'b1);
    idleBits(2);
    checkOutput("clrBeatsInc", bus.err_count, 0);

    $display("[TB] random frames");
    for (int n = 0; n < 80; n++) begin
      d = 4'($urandom_range(0, 15));
      p = ($urandom_range(0, 3) == 0) ? ~parity_bit(d, 1'b1) : parity_bit(d, 1'b1);
      applyStimulus(d, p, ($urandom_range(0, 5) != 0), $urandom_range(1, 4), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 4) == 0) driveCycle(1'b0, 1'b1, 1'b1);
      idleBits($urandom_range(0, 2));
    end
    driveCycle(1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 50 && expQ.size() != 0; k++) @(posedge clk);
    #1;
    checkOutput("pendingFrames", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
- Receive-side counterpart of the team's 4-bit odd-parity generator (parity bit = XNOR of the data bits, so data plus parity always has an odd number of ones).
- Deserialises a framed serial stream: start bit, DATA_W data bits LSB first, parity bit, stop bit.
- Checks the parity bit and the frame, presents the recovered word with a valid pulse and error flags, and keeps a saturating error count.
- Sits after the serial link, ahead of any consumer of the 4-bit words.

Parameters:
- DATA_W, 4, number of data bits per frame.
- ODD_PARITY, 1, 1 = odd parity expected (generator convention); 0 = even.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_en  in  1  bit-time strobe; rx_in is sampled only in cycles where bit_en=1.
- rx_in  in  1  serial line; idle level is 1.
- clr_err  in  1  synchronous clear of err_count.
- data_out  out  DATA_W  last received word.
- data_valid  out  1  one-cycle pulse per completed frame.
- parity_err  out  1  qualifies data_valid: parity mismatch.
- frame_err  out  1  qualifies data_valid: stop bit sampled as 0.
- busy  out  1  high while a frame is in progress (state != IDLE).
- err_count  out  CNT_W  count of frames with parity_err or frame_err; saturates.

Behaviour:
- Reset (async assert, any state): state=IDLE, bit counter=0, shift register=0. Outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0. Reset mid-frame discards the partial frame; no valid pulse is produced.
- All state changes occur only on edges where bit_en=1, except that data_valid clears and clr_err acts on any edge.
- FSM states:
  - IDLE: if bit_en and rx_in=0, go to DATA with bit counter=0. If rx_in=1, stay in IDLE. No glitch filtering.
  - DATA: on each bit_en, shift rx_in into bit[counter] (LSB first) and fold it into a running XOR. After DATA_W samples, go to PARITY.
  - PARITY: on bit_en, capture the parity bit and go to STOP.
  - STOP: on bit_en, sample the stop bit and return to IDLE. On that same edge, register data_out=shifted word, parity_err, frame_err=~rx_in, and set data_valid=1.
- Parity rule: ones = XOR(data bits, parity bit). If ODD_PARITY=1, parity_err = ~ones; if ODD_PARITY=0, parity_err = ones.
- data_valid is high for exactly one clk cycle, the cycle after the STOP-sampling edge, regardless of bit_en timing.
- parity_err and frame_err hold their values until the next frame completes. They are meaningful only while data_valid=1.
- A frame with frame_err=1 still delivers data_out and a data_valid pulse. The consumer decides whether to discard it.
- err_count:
  - Increments by 1 on the frame-completion edge when parity_err or frame_err is set.
  - Holds at 2^CNT_W-1 once reached.
  - clr_err=1 sets it to 0. If clr_err coincides with an increment, clear wins and the result is 0.
- Latency: data_valid rises 1 clk after the stop-bit bit_en edge, i.e. DATA_W+3 bit_en strobes after the start bit is sampled.
- Back-to-back frames: a start bit may be sampled on the bit_en immediately following the stop bit. No idle bit is required.
- If rx_in stays 0 through STOP (line break), set frame_err=1, return to IDLE, then treat the next low sample as a new start bit.
- If bit_en=1 in consecutive cycles, every cycle is a bit time. No minimum spacing is assumed.

Decomposition:
- Shared package parity_pkg:
  - FSM state typedef (IDLE, DATA, PARITY, STOP).
  - DATA_W default and ODD_PARITY default constants, shared with the generator.
  - parity function parity_bit(data, odd), reused by the generator and by the bench model.
- One sub-module: sat_counter (CNT_W-bit, inc/clr inputs, clear priority, saturation). Everything else stays in parity_check_rx.

Test Plan:
- Good frame: bit_en every cycle; rx_in = 0,1,1,0,1,0,1 (start, data 4'hB LSB first, parity 0, stop) -> data_out=4'hB, data_valid one-cycle pulse, parity_err=0, frame_err=0, err_count=0.
- Zero data: frame 0,0,0,0,0,1,1 -> data_out=4'h0, parity_err=0. Same frame with parity bit 0 -> parity_err=1, err_count=1.
- Bad stop: frame for 4'h5 with parity 1 and stop 0 -> data_out=4'h5, data_valid=1, frame_err=1, parity_err=0, err_count increments.
- Reset mid-frame: assert rst_n=0 after the 2nd data bit -> busy=0, no data_valid. Then send a full 4'h3 frame -> received correctly.
- bit_en sparse (1 in 5 cycles) with back-to-back frames 4'hA then 4'h6 -> two data_valid pulses, each exactly one clk wide, correct data.
- Counter: 300 parity-error frames with CNT_W=8 -> err_count=255. Assert clr_err on the completing edge of an error frame -> err_count=0.
